// File: rtl/vga_frame_reader_if.sv
// Signal bundle between the frame reader, the VGA timing driver and the SDRAM arbiter read port.
// "master" is the frame reader's view; "slave" is the driver/arbiter side.
interface vga_frame_reader_if #(
  parameter int ADDR_W = 24
);
  logic              vga_req;
  logic              vga_vsync;
  logic [15:0]       vga_din;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              frame_start;
  logic              underflow;

  modport master (
    input  vga_req, vga_vsync, rd_ack, rd_valid, rd_data,
    output vga_din, rd_req, rd_addr, frame_start, underflow
  );

  modport slave (
    output vga_req, vga_vsync, rd_ack, rd_valid, rd_data,
    input  vga_din, rd_req, rd_addr, frame_start, underflow
  );
endinterface

// File: rtl/vga_frame_reader.sv
// Prefetches one RGB565 frame per vsync through a burst read port into a FIFO and
// returns one pixel per VGA request with a fixed one-cycle latency.
module vga_frame_reader #(
  parameter int               ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'h000000,
  parameter int               FRAME_WORDS = 307200,
  parameter int               BURST_LEN   = 64,
  parameter int               FIFO_AW     = 9
) (
  input logic               clk,
  input logic               rst_n,
  vga_frame_reader_if.master bus
);

  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int BEAT_W     = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, RECV, FLUSH} state_t;

  state_t              r_state, w_state_next;
  logic                r_vsync_d;
  logic                r_flush_pend, w_flush_pend_next;
  logic [ADDR_W-1:0]   r_word_cnt, w_word_cnt_next;
  logic [BEAT_W-1:0]   r_beat_cnt, w_beat_cnt_next;
  logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [15:0]         r_vga_din;
  logic                r_frame_start;
  logic                r_underflow;

  logic                w_fall;
  logic                w_flush;
  logic                w_wr_en;
  logic                w_pop;
  logic                w_last_beat;
  logic [FIFO_AW:0]    w_free;
  logic [ADDR_W:0]     w_word_sum;

  assign w_fall      = r_vsync_d & ~bus.vga_vsync;
  assign w_free      = (FIFO_AW+1)'(FIFO_DEPTH) - r_count;
  assign w_pop       = bus.vga_req && (r_count != '0);
  assign w_last_beat = bus.rd_valid && (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign w_word_sum  = {1'b0, r_word_cnt} + (ADDR_W+1)'(BURST_LEN);

  assign bus.rd_req      = (r_state == REQ);
  assign bus.rd_addr     = BASE_ADDR + r_word_cnt;
  assign bus.vga_din     = r_vga_din;
  assign bus.frame_start = r_frame_start;
  assign bus.underflow   = r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_vsync_d    <= 1'b1;
      r_flush_pend <= 1'b0;
      r_word_cnt   <= '0;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_vsync_d    <= bus.vga_vsync;
      r_flush_pend <= w_flush_pend_next;
      r_word_cnt   <= w_word_cnt_next;
      r_beat_cnt   <= w_beat_cnt_next;
    end
  end

  // A vsync never aborts an accepted burst: it is remembered and the remaining beats are dropped.
  always_comb begin
    w_state_next      = r_state;
    w_flush_pend_next = r_flush_pend;
    w_word_cnt_next   = r_word_cnt;
    w_beat_cnt_next   = r_beat_cnt;
    w_flush           = 1'b0;
    w_wr_en           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_next = FLUSH;
        end else if (w_free >= (FIFO_AW+1)'(BURST_LEN)) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (bus.rd_ack) begin
          w_state_next    = RECV;
          w_beat_cnt_next = '0;
          if (w_fall) begin
            w_flush_pend_next = 1'b1;
          end
        end else if (w_fall) begin
          w_state_next = FLUSH;
        end
      end
      RECV: begin
        if (w_fall) begin
          w_flush_pend_next = 1'b1;
        end
        if (bus.rd_valid) begin
          w_beat_cnt_next = r_beat_cnt + BEAT_W'(1);
          w_wr_en         = ~r_flush_pend;
          if (w_last_beat) begin
            if (w_word_sum >= (ADDR_W+1)'(FRAME_WORDS)) begin
              w_word_cnt_next = '0;
            end else begin
              w_word_cnt_next = w_word_sum[ADDR_W-1:0];
            end
            w_state_next = (r_flush_pend || w_fall) ? FLUSH : IDLE;
          end
        end
      end
      FLUSH: begin
        w_flush           = 1'b1;
        w_word_cnt_next   = '0;
        w_flush_pend_next = 1'b0;
        w_state_next      = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.rd_data;
    end
  end

  // Head word is always an already-written slot, so the read never collides with the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vga_din     <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_vga_din     <= w_pop ? r_mem[r_rd_ptr] : 16'h0000;
      r_frame_start <= w_fall;
      if (bus.vga_req && (r_count == '0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: arbiter model returns data = word address + beat, a scoreboard checks the
// burst address sequence and the pixel stream; frame_start pulses and underflow are checked at phase ends.
module tb_vga_frame_reader;
  localparam int ADDR_W = 24;
  localparam int BL     = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_frame_reader_if #(.ADDR_W(ADDR_W)) bus ();

  vga_frame_reader #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (24'h000000),
    .FRAME_WORDS (256),
    .BURST_LEN   (BL),
    .FIFO_AW     (9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int fs_cnt = 0;
  int pix_idx = 0;
  int pix_seen = 0;
  bit arb_en = 1'b0;
  bit vs_inject = 1'b0;
  logic vs_main = 1'b1;
  logic vs_arb  = 1'b1;
  logic req_d = 1'b0;
  logic req_prev = 1'b0;
  logic [15:0]       pix_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  assign bus.vga_vsync = vs_main & vs_arb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel scoreboard: vga_din is due one cycle after each sampled vga_req.
  always @(posedge clk) req_d <= bus.vga_req;

  always @(negedge clk) begin
    if (req_d) begin
      if (pix_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pixel_unexpected: got 0x%0h, expected no pixel", bus.vga_din);
      end else begin
        logic [15:0] exp_pix;
        exp_pix = pix_q.pop_front();
        $display("pixel %0d: din=0x%04h exp=0x%04h", pix_seen, bus.vga_din, exp_pix);
        check("pixel", 32'(bus.vga_din), 32'(exp_pix));
        pix_seen <= pix_seen + 1;
      end
    end else begin
      check("din_idle", 32'(bus.vga_din), 32'h0);
    end
  end

  // Address scoreboard: one entry per newly raised burst request.
  always @(negedge clk) begin
    req_prev <= bus.rd_req;
    if (bus.rd_req && !req_prev) begin
      if (addr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_addr_unexpected: got 0x%0h, expected no request", bus.rd_addr);
      end else begin
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = addr_q.pop_front();
        $display("burst req: rd_addr=0x%06h exp=0x%06h", bus.rd_addr, exp_addr);
        check("rd_addr", 32'(bus.rd_addr), 32'(exp_addr));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.frame_start) fs_cnt <= fs_cnt + 1;
  end

  // Arbiter model: ack 3 cycles after a request, then BL back-to-back beats.
  initial begin : arbiter
    logic [ADDR_W-1:0] a;
    bit inj_done;
    inj_done     = 1'b0;
    bus.rd_ack   = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = 16'h0;
    forever begin
      @(negedge clk);
      if (arb_en && bus.rd_req) begin
        a = bus.rd_addr;
        repeat (3) @(negedge clk);
        if (bus.rd_req) begin
          bus.rd_ack = 1'b1;
          @(negedge clk);
          bus.rd_ack = 1'b0;
          for (int b = 0; b < BL; b++) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = a[15:0] + 16'(b);
            if (vs_inject && !inj_done && b == 19) begin
              vs_arb   = 1'b0;
              inj_done = 1'b1;
            end
            if (b == 29) vs_arb = 1'b1;
            @(negedge clk);
          end
          bus.rd_valid = 1'b0;
        end
      end
    end
  end

  task automatic read_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      bus.vga_req = 1'b1;
      pix_q.push_back(16'(pix_idx % 256));
      pix_idx++;
      @(negedge clk);
    end
    bus.vga_req = 1'b0;
  endtask

  task automatic read_empty(input int n);
    for (int i = 0; i < n; i++) begin
      bus.vga_req = 1'b1;
      pix_q.push_back(16'h0000);
      @(negedge clk);
    end
    bus.vga_req = 1'b0;
  endtask

  task automatic push_cycle(input int first, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(ADDR_W'(((first + i) % 4) * 64));
  endtask

  initial begin : main
    bus.vga_req = 1'b0;
    addr_q.push_back(24'h000000);
    repeat (3) @(negedge clk);
    check("reset_rd_req", 32'(bus.rd_req), 32'h0);
    check("reset_rd_addr", 32'(bus.rd_addr), 32'h0);
    check("reset_underflow", 32'(bus.underflow), 32'h0);
    check("reset_frame_start", 32'(bus.frame_start), 32'h0);
    rst_n = 1'b1;

    // Arbiter silent: request held at base address
    repeat (5) @(negedge clk);
    check("hold_rd_req", 32'(bus.rd_req), 32'h1);
    check("hold_rd_addr", 32'(bus.rd_addr), 32'h0);

    // Fill: 8 bursts with address wrap at 256 words
    push_cycle(1, 7);
    arb_en = 1'b1;
    repeat (900) @(negedge clk);
    check("full_no_req", 32'(bus.rd_req), 32'h0);
    check("fill_addr_left", 32'(addr_q.size()), 32'h0);

    // Stream 640 pixels while refilling: exactly 10 refill bursts
    push_cycle(0, 10);
    read_pixels(640);
    repeat (900) @(negedge clk);
    check("stream_underflow", 32'(bus.underflow), 32'h0);
    check("stream_addr_left", 32'(addr_q.size()), 32'h0);
    check("stream_pix_left", 32'(pix_q.size()), 32'h0);
    check("stream_fs_cnt", 32'(fs_cnt), 32'h0);

    // Vsync at beat 20 of the 0x80 burst, then prefetch restarts at base
    addr_q.push_back(24'h000080);
    push_cycle(0, 8);
    vs_inject = 1'b1;
    read_pixels(64);
    repeat (1000) @(negedge clk);
    check("flush_fs_cnt", 32'(fs_cnt), 32'h1);
    check("flush_addr_left", 32'(addr_q.size()), 32'h0);
    check("flush_pix_left", 32'(pix_q.size()), 32'h0);

    pix_idx = 0;
    addr_q.push_back(24'h000000);
    read_pixels(64);
    repeat (300) @(negedge clk);
    check("post_flush_addr_left", 32'(addr_q.size()), 32'h0);
    check("post_flush_pix_left", 32'(pix_q.size()), 32'h0);
    check("post_flush_underflow", 32'(bus.underflow), 32'h0);

    // Arbiter stops answering: flush empties FIFO, then read from empty
    arb_en = 1'b0;
    addr_q.push_back(24'h000000);
    vs_main = 1'b0;
    repeat (5) @(negedge clk);
    vs_main = 1'b1;
    repeat (10) @(negedge clk);
    check("empty_fs_cnt", 32'(fs_cnt), 32'h2);
    check("empty_rd_req", 32'(bus.rd_req), 32'h1);
    read_empty(3);
    repeat (2) @(negedge clk);
    check("underflow_set", 32'(bus.underflow), 32'h1);

    // Vsync while requesting withdraws and reissues at base; underflow is sticky
    addr_q.push_back(24'h000000);
    vs_main = 1'b0;
    repeat (5) @(negedge clk);
    vs_main = 1'b1;
    repeat (10) @(negedge clk);
    check("withdraw_fs_cnt", 32'(fs_cnt), 32'h3);
    check("underflow_sticky", 32'(bus.underflow), 32'h1);
    check("reissue_rd_req", 32'(bus.rd_req), 32'h1);
    check("reissue_addr_left", 32'(addr_q.size()), 32'h0);
    check("underflow_pix_left", 32'(pix_q.size()), 32'h0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rereset_underflow", 32'(bus.underflow), 32'h0);
    check("rereset_rd_req", 32'(bus.rd_req), 32'h0);
    check("rereset_rd_addr", 32'(bus.rd_addr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
